// File: rtl/camera_transform_pipe.sv
// camera_transform_pipe: world-to-camera transform (translate, then Rz/Ry/Rx) with primitive assembly and an output FIFO.
// Vertex = {x,y,z,colour}, 32b each (x,y,z Q16.16); transform = {pos,rot_sin,rot_cos}, each {x,y,z}. Define CAMERA_NEAR_CULL_EN for near-plane culling.
module camera_transform_pipe #(
  parameter int VERTS     = 3,
  parameter int OUT_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          focal_length,
  input  logic [287:0]         camera_transform,
  input  logic [VERTS*128-1:0] in_prim,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [VERTS*128-1:0] out_prim,
  output logic [31:0]          out_focal_length,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 culled,
  output logic                 busy
);
  localparam int VW = 128;
  localparam int PW = VERTS * VW;
  localparam int IW = (VERTS > 1) ? $clog2(VERTS) : 1;
  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = 4;

  typedef enum logic {LD_IDLE, LD_ISSUE} ld_state_t;

  ld_state_t     state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          run_q, accept, issue_last;
  logic [PW-1:0] cap_prim;
  logic [287:0]  cap_xf;
  logic [31:0]   cap_focal;
  logic [VW-1:0] iss_vtx;

  logic          tr_valid, rz_valid, ry_valid;
  logic [IW-1:0] tr_idx, rz_idx, ry_idx;
  logic [31:0]   tr_x, tr_y, tr_z, tr_col, tr_f;
  logic [31:0]   tr_sx, tr_sy, tr_sz, tr_cx, tr_cy, tr_cz;
  logic [31:0]   rz_x, rz_y, rz_z, rz_col, rz_f, rz_sx, rz_sy, rz_cx, rz_cy;
  logic [31:0]   ry_x, ry_y, ry_z, ry_col, ry_f, ry_sx, ry_cx;
  logic [31:0]   rx_y, rx_z;
  logic [VW-1:0] new_vtx;
  logic [VW-1:0] asm_q [VERTS];
  logic [PW-1:0] asm_d;

  logic [PW-1:0] fifo_prim [OUT_DEPTH];
  logic [31:0]   fifo_focal [OUT_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt, resv_cnt;
  logic          push, pop, last_wr, cull_hit;

  // Q16.16 multiply: full signed product, arithmetic shift, keep low 32 bits.
  function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return 32'(p >>> 16);
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(OUT_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign issue_last = (state_q == LD_ISSUE) && (idx_q == IW'(VERTS - 1));
  assign in_ready   = run_q && ((state_q == LD_IDLE) || issue_last) &&
                      ((fifo_cnt + resv_cnt) < CW'(OUT_DEPTH));
  assign accept     = in_valid && in_ready;
  assign iss_vtx    = cap_prim[idx_q*VW +: VW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD_IDLE;
      idx_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (accept) begin
      state_d = LD_ISSUE;
      idx_d   = '0;
    end else if (issue_last) begin
      state_d = LD_IDLE;
    end else if (state_q == LD_ISSUE) begin
      idx_d = idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_prim  <= in_prim;
      cap_xf    <= camera_transform;
      cap_focal <= focal_length;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tr_valid <= 1'b0;
      rz_valid <= 1'b0;
      ry_valid <= 1'b0;
    end else begin
      tr_valid <= (state_q == LD_ISSUE);
      rz_valid <= tr_valid;
      ry_valid <= rz_valid;
    end
  end

  // Transform parameters travel with each vertex so a new primitive can be captured mid-flight.
  always_ff @(posedge clk) begin
    tr_idx <= idx_q;
    tr_x   <= iss_vtx[127:96] - cap_xf[287:256];
    tr_y   <= iss_vtx[95:64]  - cap_xf[255:224];
    tr_z   <= iss_vtx[63:32]  - cap_xf[223:192];
    tr_col <= iss_vtx[31:0];
    tr_f   <= cap_focal;
    tr_sx  <= cap_xf[191:160];
    tr_sy  <= cap_xf[159:128];
    tr_sz  <= cap_xf[127:96];
    tr_cx  <= cap_xf[95:64];
    tr_cy  <= cap_xf[63:32];
    tr_cz  <= cap_xf[31:0];

    rz_idx <= tr_idx;
    rz_x   <= qmul(tr_cz, tr_x) + qmul(tr_sz, tr_y);
    rz_y   <= qmul(tr_cz, tr_y) - qmul(tr_sz, tr_x);
    rz_z   <= tr_z;
    rz_col <= tr_col;
    rz_f   <= tr_f;
    rz_sx  <= tr_sx;
    rz_sy  <= tr_sy;
    rz_cx  <= tr_cx;
    rz_cy  <= tr_cy;

    ry_idx <= rz_idx;
    ry_x   <= qmul(rz_cy, rz_x) - qmul(rz_sy, rz_z);
    ry_y   <= rz_y;
    ry_z   <= qmul(rz_sy, rz_x) + qmul(rz_cy, rz_z);
    ry_col <= rz_col;
    ry_f   <= rz_f;
    ry_sx  <= rz_sx;
    ry_cx  <= rz_cx;
  end

  assign rx_y    = qmul(ry_cx, ry_y) + qmul(ry_sx, ry_z);
  assign rx_z    = qmul(ry_cx, ry_z) - qmul(ry_sx, ry_y);
  assign new_vtx = {ry_x, rx_y, rx_z, ry_col};
  assign last_wr = ry_valid && (ry_idx == IW'(VERTS - 1));

  always_ff @(posedge clk) begin
    if (ry_valid) asm_q[ry_idx] <= new_vtx;
  end

  // The final vertex bypasses its assembly slot so the push happens on the same edge it is written.
  always_comb begin
    asm_d = '0;
    for (int i = 0; i < VERTS; i++)
      asm_d[i*VW +: VW] = (ry_idx == IW'(i)) ? new_vtx : asm_q[i];
  end

`ifdef CAMERA_NEAR_CULL_EN
  logic all_behind;

  always_comb begin
    all_behind = 1'b1;
    for (int i = 0; i < VERTS; i++)
      if ($signed(asm_d[i*VW+32 +: 32]) > 0) all_behind = 1'b0;
  end

  assign cull_hit = last_wr && all_behind;
`else
  assign cull_hit = 1'b0;
`endif

  assign culled = cull_hit;
  assign push   = last_wr && !cull_hit;
  assign pop    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_prim[wr_ptr]  <= asm_d;
      fifo_focal[wr_ptr] <= ry_f;
    end
  end

  // A primitive's reservation is released when its last vertex leaves the pipe, pushed or culled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      resv_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      resv_cnt <= resv_cnt + CW'(accept) - CW'(last_wr);
    end
  end

  assign out_valid        = (fifo_cnt != '0);
  assign out_prim         = out_valid ? fifo_prim[rd_ptr] : '0;
  assign out_focal_length = out_valid ? fifo_focal[rd_ptr] : '0;
  assign busy             = (state_q == LD_ISSUE) || tr_valid || rz_valid || ry_valid || out_valid;

endmodule
